// File: rtl/inst_axi_bridge_pkg.sv
// -----------------------------------------------------------------------------
// inst_axi_bridge_pkg
//   Shared definitions for the instruction-side SRAM-to-AXI3 read bridge:
//   bridge FSM state encodings, fixed AXI burst/response codes, and a small
//   helper that classifies an R-channel response as an error.
//   Optional feature macro used by the bridge: INST_BRIDGE_ERR_EN.
// -----------------------------------------------------------------------------
package inst_axi_bridge_pkg;

    typedef enum logic [1:0] {
        BR_IDLE = 2'd0,
        BR_AR   = 2'd1,
        BR_R    = 2'd2,
        BR_RESP = 2'd3
    } br_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // SLVERR (2'b10) and DECERR (2'b11) both carry bit 1; OKAY/EXOKAY do not.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/inst_axi_bridge_kseg_map.sv
// -----------------------------------------------------------------------------
// inst_axi_bridge_kseg_map
//   Pure combinational virtual-to-physical address map. Addresses in the
//   kseg0/kseg1 windows (top two bits 2'b10) have their top three bits
//   cleared; every other address passes through unchanged.
//   Shared with the data-side bridge.
// Ports:
//   i_vaddr  in   ADDR_W  virtual address
//   o_paddr  out  ADDR_W  physical address
// -----------------------------------------------------------------------------
module inst_axi_bridge_kseg_map #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_vaddr,
    output logic [ADDR_W-1:0] o_paddr
);

    always_comb begin
        o_paddr = i_vaddr;
        if (i_vaddr[ADDR_W-1 -: 2] == 2'b10) begin
            o_paddr = {3'b000, i_vaddr[ADDR_W-4:0]};
        end
    end

endmodule

// File: rtl/inst_axi_bridge.sv
// -----------------------------------------------------------------------------
// inst_axi_bridge
//   Instruction-fetch SRAM-like slave to AXI3 single-beat read master.
//   Accepts one fetch at a time from the IF stage, translates the address
//   through kseg_map, issues one AR, waits for the matching R beat and
//   returns the word with a one-cycle data_ok pulse. Read-only.
//   Sequence per fetch: IDLE (addr_ok) -> AR -> R -> RESP (data_ok) -> IDLE.
//
// Configuration:
//   INST_BRIDGE_ERR_EN  when defined, adds output inst_sram_err, raised with
//                       data_ok if the captured rresp was SLVERR/DECERR; the
//                       returned word is then forced to 32'h0 (a nop).
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   inst_sram_en/addr/size        fetch request from IF
//   inst_sram_wr/wen/wdata        unused (write path does not exist here)
//   inst_sram_addr_ok             request accepted this cycle
//   inst_sram_data_ok             one-cycle pulse, inst_sram_rdata valid
//   inst_sram_rdata               fetched word, held until next data_ok
//   inst_sram_err                 (INST_BRIDGE_ERR_EN only) bus error
//   ar*                           AXI3 read address channel (master)
//   rid/rdata/rresp/rlast/rvalid  AXI3 read data channel (inputs)
//   rready                        AXI3 read data ready
// -----------------------------------------------------------------------------
module inst_axi_bridge
    import inst_axi_bridge_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd0,
    parameter int         ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              inst_sram_en,
    input  logic              inst_sram_wr,
    input  logic [1:0]        inst_sram_size,
    input  logic [3:0]        inst_sram_wen,
    input  logic [ADDR_W-1:0] inst_sram_addr,
    input  logic [31:0]       inst_sram_wdata,
    output logic              inst_sram_addr_ok,
    output logic              inst_sram_data_ok,
    output logic [31:0]       inst_sram_rdata,
`ifdef INST_BRIDGE_ERR_EN
    output logic              inst_sram_err,
`endif

    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [3:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [1:0]        arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,

    input  logic [3:0]        rid,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready
);

    br_state_t         r_state;
    br_state_t         w_state_next;

    logic [ADDR_W-1:0] r_araddr;
    logic [1:0]        r_size;
    logic [31:0]       r_rdata;

    logic [ADDR_W-1:0] w_paddr;
    logic              w_addr_ok;
    logic              w_arvalid;
    logic              w_rready;
    logic              w_data_ok;
    logic              w_beat_ours;
    logic              w_capture;
    logic [31:0]       w_capture_data;

    // Write-side inputs exist only for interface compatibility with IF.
`ifdef INST_BRIDGE_ERR_EN
    logic              r_err;
    logic              w_unused;
    assign w_unused = ^{inst_sram_wr, inst_sram_wen, inst_sram_wdata};
`else
    logic              w_unused;
    assign w_unused = ^{inst_sram_wr, inst_sram_wen, inst_sram_wdata, rresp};
`endif

    inst_axi_bridge_kseg_map #(
        .ADDR_W (ADDR_W)
    ) u_kseg_map (
        .i_vaddr (inst_sram_addr),
        .o_paddr (w_paddr)
    );

    // Single-beat read: only the last beat carrying our id completes the
    // transaction; foreign-id beats are drained (rready stays high) and dropped.
    assign w_beat_ours = rvalid && (rid == AXI_ID) && rlast;
    assign w_capture   = w_rready && w_beat_ours;

`ifdef INST_BRIDGE_ERR_EN
    assign w_capture_data = resp_is_err(rresp) ? 32'h0 : rdata;
`else
    assign w_capture_data = rdata;
`endif

    // Next-state and handshake outputs. addr_ok is combinational from en so
    // IF sees acceptance in the same cycle it raises the request.
    always_comb begin
        w_state_next = r_state;
        w_addr_ok    = 1'b0;
        w_arvalid    = 1'b0;
        w_rready     = 1'b0;
        w_data_ok    = 1'b0;
        case (r_state)
            BR_IDLE: begin
                w_addr_ok = inst_sram_en;
                if (inst_sram_en) begin
                    w_state_next = BR_AR;
                end
            end
            BR_AR: begin
                // Once raised, arvalid is held until the handshake even if
                // IF withdraws the request.
                w_arvalid = 1'b1;
                if (arready) begin
                    w_state_next = BR_R;
                end
            end
            BR_R: begin
                w_rready = 1'b1;
                if (w_beat_ours) begin
                    w_state_next = BR_RESP;
                end
            end
            BR_RESP: begin
                w_data_ok    = 1'b1;
                w_state_next = BR_IDLE;
            end
            default: begin
                w_state_next = BR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= BR_IDLE;
            r_araddr <= '0;
            r_size   <= 2'b00;
            r_rdata  <= 32'h0;
`ifdef INST_BRIDGE_ERR_EN
            r_err    <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            // Address and size frozen at acceptance keep AR stable while
            // arready is low, independent of what IF drives afterwards.
            if (w_addr_ok) begin
                r_araddr <= w_paddr;
                r_size   <= inst_sram_size;
            end
            // rdata only moves on capture; IF reads it after data_ok.
            if (w_capture) begin
                r_rdata <= w_capture_data;
`ifdef INST_BRIDGE_ERR_EN
                r_err   <= resp_is_err(rresp);
`endif
            end
        end
    end

    assign inst_sram_addr_ok = w_addr_ok;
    assign inst_sram_data_ok = w_data_ok;
    assign inst_sram_rdata   = r_rdata;
`ifdef INST_BRIDGE_ERR_EN
    assign inst_sram_err     = w_data_ok && r_err;
`endif

    assign arid    = AXI_ID;
    assign araddr  = r_araddr;
    assign arlen   = 4'd0;
    assign arsize  = {1'b0, r_size};
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign arvalid = w_arvalid;
    assign rready  = w_rready;

endmodule

// File: tb/tb_inst_axi_bridge.sv
// -----------------------------------------------------------------------------
// tb_inst_axi_bridge
//   Directed bench for inst_axi_bridge. A behavioural model tracks the one
//   fetch in flight (accepted -> AR pending -> R pending -> data due) and is
//   compared with the DUT on every falling edge; directed tests add literal
//   expectations for addresses, latencies, counts and held data.
// -----------------------------------------------------------------------------
module tb_inst_axi_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_en, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
`ifdef INST_BRIDGE_ERR_EN
    logic        inst_sram_err;
`endif
    logic [3:0]  arid, arlen, arcache;
    logic [31:0] araddr;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    always #5 clk = ~clk;

    inst_axi_bridge dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_en      (inst_sram_en),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wen     (inst_sram_wen),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
`ifdef INST_BRIDGE_ERR_EN
        .inst_sram_err     (inst_sram_err),
`endif
        .arid              (arid),
        .araddr            (araddr),
        .arlen             (arlen),
        .arsize            (arsize),
        .arburst           (arburst),
        .arlock            (arlock),
        .arcache           (arcache),
        .arprot            (arprot),
        .arvalid           (arvalid),
        .arready           (arready),
        .rid               (rid),
        .rdata             (rdata),
        .rresp             (rresp),
        .rlast             (rlast),
        .rvalid            (rvalid),
        .rready            (rready)
    );

    int vectors = 0;
    int fails   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // kseg0/kseg1 windows (0x8000_0000..0xBFFF_FFFF) fold onto the low 512 MiB.
    function automatic logic [31:0] xlate(input logic [31:0] a);
        if ((a / 32'h4000_0000) == 32'd2) return a % 32'h2000_0000;
        return a;
    endfunction

    // ---------------- model state ----------------
    bit          chk_en = 0;
    bit          busy, ar_pending, r_pending, resp_due, err_due;
    logic [31:0] exp_addr, last_data;
    logic [1:0]  exp_size;
    int          cyc = 0;

    // ---------------- monitor counters ----------------
    int          addrok_count = 0, dataok_count = 0, ar_hs_count = 0, arvalid_cycles = 0;
    int          addrok_cyc = 0, dataok_cyc = 0;
    logic [31:0] last_ar_addr = 32'h0;
    logic        err_at_dataok = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        busy = 0; ar_pending = 0; r_pending = 0; resp_due = 0; err_due = 0;
        exp_addr = 32'h0; last_data = 32'h0; exp_size = 2'b00;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                logic e_addr_ok;
                e_addr_ok = inst_sram_en && !busy;
                chk("addr_ok", inst_sram_addr_ok, e_addr_ok);
                chk("arvalid", arvalid, ar_pending);
                chk("rready", rready, r_pending);
                chk("data_ok", inst_sram_data_ok, resp_due);
                chk("rdata", inst_sram_rdata, last_data);
                chk("ar_fixed", {arid, arlen, arburst, arlock, arcache, arprot},
                    {4'd0, 4'd0, 2'b01, 2'b00, 4'd0, 3'd0});
                if (ar_pending) begin
                    chk("araddr", araddr, exp_addr);
                    chk("arsize", arsize, {1'b0, exp_size});
                end
`ifdef INST_BRIDGE_ERR_EN
                chk("err", inst_sram_err, resp_due && err_due);
                if (inst_sram_data_ok) err_at_dataok = inst_sram_err;
`endif
                if (inst_sram_addr_ok) begin addrok_count++; addrok_cyc = cyc; end
                if (inst_sram_data_ok) begin dataok_count++; dataok_cyc = cyc; end
                if (arvalid) begin arvalid_cycles++; last_ar_addr = araddr; end
                if (arvalid && arready) ar_hs_count++;

                // advance the model to the state after this clock edge
                if (reset) begin
                    busy = 0; ar_pending = 0; r_pending = 0; resp_due = 0; err_due = 0;
                    last_data = 32'h0;
                end else begin
                    if (resp_due) begin resp_due = 0; busy = 0; end
                    if (r_pending && rvalid && rid == 4'd0 && rlast) begin
                        r_pending = 0;
                        resp_due  = 1;
`ifdef INST_BRIDGE_ERR_EN
                        err_due   = (rresp == 2'b10) || (rresp == 2'b11);
                        last_data = err_due ? 32'h0 : rdata;
`else
                        last_data = rdata;
`endif
                    end
                    if (ar_pending && arready) begin ar_pending = 0; r_pending = 1; end
                    if (e_addr_ok) begin
                        busy = 1; ar_pending = 1;
                        exp_addr = xlate(inst_sram_addr);
                        exp_size = inst_sram_size;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dataok(input int max_cycles);
        int start;
        start = dataok_count;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (dataok_count != start) break;
        end
        chk("data_ok_timeout", (dataok_count != start), 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_a, base_b, d1;
        reset = 1'b1;
        inst_sram_en = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_wen = 4'h0;
        inst_sram_addr = 32'h0; inst_sram_wdata = 32'h0;
        arready = 0; rid = 4'd0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b1; rvalid = 0;

        repeat (2) tick();
        chk_en = 1;
        chk("rst_addr_ok", inst_sram_addr_ok, 1'b0);
        chk("rst_data_ok", inst_sram_data_ok, 1'b0);
        chk("rst_rdata", inst_sram_rdata, 32'h0);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_rready", rready, 1'b0);
        tick();
        reset = 1'b0;
        tick();

        // 1: immediate arready/rvalid, minimum latency, held data
        arready = 1; rvalid = 1; rid = 4'd0; rdata = 32'h3c1a0000;
        inst_sram_addr = 32'hbfc00000; inst_sram_en = 1;
        tick();
        inst_sram_en = 0;
        wait_dataok(20);
        chk("t1_araddr", last_ar_addr, 32'h1fc00000);
        chk("t1_latency", dataok_cyc - addrok_cyc, 3);
        rvalid = 0; rdata = 32'h0;
        repeat (3) tick();
        chk("t1_hold", inst_sram_rdata, 32'h3c1a0000);

        // 2: arready low for 5 AR cycles
        base_a = addrok_count; base_b = arvalid_cycles;
        arready = 0; inst_sram_addr = 32'h9fc00010; inst_sram_en = 1;
        repeat (6) tick();
        arready = 1; inst_sram_en = 0; rvalid = 1; rdata = 32'h24080001;
        wait_dataok(20);
        chk("t2_arvalid_cycles", arvalid_cycles - base_b, 6);
        chk("t2_addr_ok_once", addrok_count - base_a, 1);
        chk("t2_araddr", last_ar_addr, 32'h1fc00010);
        rvalid = 0;

        // 3: en dropped after acceptance, rvalid late
        base_a = ar_hs_count; base_b = dataok_count;
        inst_sram_addr = 32'hbfc00100; inst_sram_en = 1;
        tick();
        inst_sram_en = 0;
        repeat (4) tick();
        rvalid = 1; rdata = 32'h00000001;
        wait_dataok(20);
        rvalid = 0;
        repeat (3) tick();
        chk("t3_one_ar", ar_hs_count - base_a, 1);
        chk("t3_one_data_ok", dataok_count - base_b, 1);
        chk("t3_rdata", inst_sram_rdata, 32'h00000001);

        // 4: back-to-back fetches with en held high
        base_a = addrok_count;
        rvalid = 1; rdata = 32'h11111111;
        inst_sram_addr = 32'hbfc00000; inst_sram_en = 1;
        tick();
        inst_sram_addr = 32'hbfc00004;
        wait_dataok(20);
        d1 = dataok_cyc;
        chk("t4_first_rdata", inst_sram_rdata, 32'h11111111);
        rdata = 32'h22222222;
        tick();
        inst_sram_en = 0;
        chk("t4_second_addr_ok_cycle", addrok_cyc, d1 + 1);
        chk("t4_addr_ok_count", addrok_count - base_a, 2);
        wait_dataok(20);
        chk("t4_second_rdata", inst_sram_rdata, 32'h22222222);
        chk("t4_second_araddr", last_ar_addr, 32'h1fc00004);
        rvalid = 0;

        // 5: foreign-id beat ignored
        inst_sram_addr = 32'hbfc00200; inst_sram_en = 1;
        tick();
        inst_sram_en = 0;
        tick();
        rvalid = 1; rid = 4'd3; rdata = 32'hdeadbeef;
        tick();
        rid = 4'd0; rdata = 32'hcafef00d;
        wait_dataok(20);
        chk("t5_rdata", inst_sram_rdata, 32'hcafef00d);
        chk("t5_latency", dataok_cyc - addrok_cyc, 4);
        rvalid = 0;

        // 6: reset while waiting in R
        inst_sram_addr = 32'hbfc00300; inst_sram_en = 1;
        tick();
        inst_sram_en = 0;
        repeat (2) tick();
        reset = 1;
        tick();
        reset = 0;
        chk("t6_rready", rready, 1'b0);
        chk("t6_arvalid", arvalid, 1'b0);
        chk("t6_rdata", inst_sram_rdata, 32'h0);
        base_b = dataok_count;
        rvalid = 1; rdata = 32'h00000055;
        repeat (4) tick();
        chk("t6_no_data_ok", dataok_count - base_b, 0);
        rvalid = 0;

        // 7: error response (nop substituted only when error reporting exists)
        rvalid = 1; rresp = 2'b10; rdata = 32'h12345678;
        inst_sram_addr = 32'h00400000; inst_sram_en = 1;
        tick();
        inst_sram_en = 0;
        wait_dataok(20);
        chk("t7_araddr_passthrough", last_ar_addr, 32'h00400000);
`ifdef INST_BRIDGE_ERR_EN
        chk("t7_err", err_at_dataok, 1'b1);
        chk("t7_rdata", inst_sram_rdata, 32'h0);
`else
        chk("t7_rdata", inst_sram_rdata, 32'h12345678);
`endif
        rvalid = 0; rresp = 2'b00;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
